// File: rtl/dmem_mmio.sv
// Data-memory responder for the MIPS data port: word RAM plus an MMIO page (OUT, IN, timer).
// Optional misaligned-store suppression is compiled in with `define DMEM_ALIGN_CHECK_EN.
module dmem_mmio #(
  parameter int ADDR_BITS = 6,
  parameter int IO_WIDTH  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                memwrite,
  input  logic [31:0]         aluout,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  input  logic [IO_WIDTH-1:0] io_in,
  output logic [IO_WIDTH-1:0] io_out,
  output logic                timer_irq,
  output logic                misalign
);

  logic [31:0]         ram [0:(2**ADDR_BITS)-1];
  logic [IO_WIDTH-1:0] out_reg;
  logic [IO_WIDTH-1:0] sync1, sync2;
  logic [31:0]         count, cmp;
  logic                ctrl_en;
  logic                pending;
  logic                wr_ok;

  logic sel_ram, sel_out, sel_in, sel_count, sel_cmp, sel_ctrl, sel_stat;

  // Word-level decode: aluout[1:0] never takes part in selecting a location.
  assign sel_ram   = (aluout[31:16] == 16'h0000);
  assign sel_out   = (aluout[31:2] == 30'(32'hFFFF_0000 >> 2));
  assign sel_in    = (aluout[31:2] == 30'(32'hFFFF_0004 >> 2));
  assign sel_count = (aluout[31:2] == 30'(32'hFFFF_0008 >> 2));
  assign sel_cmp   = (aluout[31:2] == 30'(32'hFFFF_000C >> 2));
  assign sel_ctrl  = (aluout[31:2] == 30'(32'hFFFF_0010 >> 2));
  assign sel_stat  = (aluout[31:2] == 30'(32'hFFFF_0014 >> 2));

  logic unused_addr_bits;
  assign unused_addr_bits = ^{aluout[15:ADDR_BITS+2], aluout[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
  logic misalign_q;
  assign wr_ok    = memwrite && (aluout[1:0] == 2'b00);
  assign misalign = misalign_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      misalign_q <= 1'b0;
    else if (memwrite && (aluout[1:0] != 2'b00))
      misalign_q <= 1'b1;
  end
`else
  assign wr_ok    = memwrite;
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (wr_ok && sel_ram)
      ram[aluout[ADDR_BITS+1:2]] <= writedata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_reg <= '0;
      sync1   <= '0;
      sync2   <= '0;
      count   <= '0;
      cmp     <= '0;
      ctrl_en <= 1'b0;
      pending <= 1'b0;
    end else begin
      sync1 <= io_in;
      sync2 <= sync1;
      if (wr_ok && sel_out)
        out_reg <= writedata[IO_WIDTH-1:0];
      if (wr_ok && sel_cmp)
        cmp <= writedata;
      if (wr_ok && sel_ctrl)
        ctrl_en <= writedata[0];
      // A software load of COUNT takes precedence over the running increment.
      if (wr_ok && sel_count)
        count <= writedata;
      else if (ctrl_en)
        count <= count + 32'd1;
      // Match uses the pre-increment COUNT; a simultaneous set beats a clear.
      if (ctrl_en && (count == cmp))
        pending <= 1'b1;
      else if (wr_ok && sel_stat && writedata[0])
        pending <= 1'b0;
    end
  end

  always_comb begin
    readdata = 32'h0;
    if (sel_ram)
      readdata = ram[aluout[ADDR_BITS+1:2]];
    else if (sel_out)
      readdata = 32'(out_reg);
    else if (sel_in)
      readdata = 32'(sync2);
    else if (sel_count)
      readdata = count;
    else if (sel_cmp)
      readdata = cmp;
    else if (sel_ctrl)
      readdata = {31'h0, ctrl_en};
    else if (sel_stat)
      readdata = {31'h0, pending};
  end

  assign io_out    = out_reg;
  assign timer_irq = pending;

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed self-checking bench for dmem_mmio: RAM, OUT/IN, timer/irq, wrap, async reset, alignment.
module tb_dmem_mmio;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [15:0] io_in;
  logic [15:0] io_out;
  logic        timer_irq;
  logic        misalign;

  int total  = 0;
  int passed = 0;

  localparam logic [31:0] A_OUT   = 32'hFFFF_0000;
  localparam logic [31:0] A_IN    = 32'hFFFF_0004;
  localparam logic [31:0] A_COUNT = 32'hFFFF_0008;
  localparam logic [31:0] A_CMP   = 32'hFFFF_000C;
  localparam logic [31:0] A_CTRL  = 32'hFFFF_0010;
  localparam logic [31:0] A_STAT  = 32'hFFFF_0014;

  dmem_mmio dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .aluout    (aluout),
    .writedata (writedata),
    .readdata  (readdata),
    .io_in     (io_in),
    .io_out    (io_out),
    .timer_irq (timer_irq),
    .misalign  (misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    memwrite  = 1'b1;
    aluout    = addr;
    writedata = data;
    @(posedge clk);
    #1;
    memwrite  = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    aluout = addr;
    #1;
    chk(tag, readdata, exp);
  endtask

  initial begin
    reset = 1'b1; memwrite = 1'b0; aluout = 32'h0; writedata = 32'h0; io_in = 16'h0;
    #12;
    rd("rst_out", A_OUT, 32'h0);
    rd("rst_count", A_COUNT, 32'h0);
    rd("rst_ctrl", A_CTRL, 32'h0);
    chk("rst_irq", {31'h0, timer_irq}, 32'h0);
    chk("rst_misalign", {31'h0, misalign}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // RAM store/load, aliasing, unmapped
    do_write(32'h0000_0010, 32'hDEAD_BEEF);
    rd("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
    rd("ram_alias", 32'h0000_0110, 32'hDEAD_BEEF);
    rd("unmapped", 32'hFFFF_0020, 32'h0);

    // Same-cycle read/write: old value before the edge, new value after
    @(negedge clk);
    memwrite = 1'b1; aluout = 32'h0000_0010; writedata = 32'hCAFE_F00D;
    #1;
    chk("rw_old", readdata, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    memwrite = 1'b0;
    chk("rw_new", readdata, 32'hCAFE_F00D);

    // OUT register
    do_write(A_OUT, 32'h1234_A5A5);
    chk("io_out", {16'h0, io_out}, 32'h0000_A5A5);
    rd("out_rd", A_OUT, 32'h0000_A5A5);

    // IN synchronizer: two-edge latency
    @(negedge clk);
    io_in = 16'h00C3; aluout = A_IN;
    #1;
    chk("in_0edge", readdata, 32'h0);
    @(posedge clk); #1;
    chk("in_1edge", readdata, 32'h0);
    @(posedge clk); #1;
    chk("in_2edge", readdata, 32'h0000_00C3);
    do_write(A_IN, 32'h0000_FFFF);
    rd("in_ro", A_IN, 32'h0000_00C3);

    // Timer counting and compare interrupt
    do_write(A_CMP, 32'd5);
    do_write(A_COUNT, 32'd0);
    do_write(A_CTRL, 32'd1);
    rd("cnt_0", A_COUNT, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("cnt_%0d", i), readdata, 32'(i));
    end
    chk("irq_not_yet", {31'h0, timer_irq}, 32'h0);
    @(posedge clk); #1;
    chk("irq_set", {31'h0, timer_irq}, 32'h1);
    rd("stat_rd", A_STAT, 32'h1);
    do_write(A_STAT, 32'h1);
    chk("irq_clr", {31'h0, timer_irq}, 32'h0);

    // Set wins over a simultaneous clear (count = 7 here)
    do_write(A_CTRL, 32'd0);
    rd("cnt_hold8", A_COUNT, 32'd8);
    do_write(A_CMP, 32'd8);
    do_write(A_CTRL, 32'd1);
    chk("irq_pre_match", {31'h0, timer_irq}, 32'h0);
    do_write(A_STAT, 32'h1);
    chk("irq_set_wins", {31'h0, timer_irq}, 32'h1);

    // Wrap and write-over-increment priority
    do_write(A_COUNT, 32'hFFFF_FFFE);
    rd("wrap_load", A_COUNT, 32'hFFFF_FFFE);
    @(posedge clk); #1;
    chk("wrap_max", readdata, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    chk("wrap_zero", readdata, 32'h0);
    do_write(A_COUNT, 32'd100);
    rd("cnt_load100", A_COUNT, 32'd100);
    @(posedge clk); #1;
    chk("cnt_101", readdata, 32'd101);

    // Async reset between edges
    do_write(A_OUT, 32'h0000_FFFF);
    chk("out_ffff", {16'h0, io_out}, 32'h0000_FFFF);
    chk("irq_before_rst", {31'h0, timer_irq}, 32'h1);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_out", {16'h0, io_out}, 32'h0);
    chk("arst_irq", {31'h0, timer_irq}, 32'h0);
    rd("arst_count", A_COUNT, 32'h0);
    rd("arst_in", A_IN, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    rd("ram_kept", 32'h0000_0010, 32'hCAFE_F00D);

    // Misaligned store
    do_write(32'h0000_0012, 32'h55AA_55AA);
`ifdef DMEM_ALIGN_CHECK_EN
    rd("mis_ram", 32'h0000_0010, 32'hCAFE_F00D);
    chk("mis_flag", {31'h0, misalign}, 32'h1);
    @(posedge clk); #1;
    chk("mis_sticky", {31'h0, misalign}, 32'h1);
    #1; reset = 1'b1; #1;
    chk("mis_rst", {31'h0, misalign}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
`else
    rd("mis_ram", 32'h0000_0010, 32'h55AA_55AA);
    rd("mis_ram_lowbits", 32'h0000_0013, 32'h55AA_55AA);
    chk("mis_flag", {31'h0, misalign}, 32'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
